// File: rtl/i2s_transmitter.sv
// Philips I2S serialiser with one-frame holding buffer and on-chip BCLK/LRCLK.
// Optional: define I2S_TX_UNDERFLOW_MUTE_EN to send silence on underflow.
module i2s_transmitter #(
  parameter int DATA_WIDTH       = 24,
  parameter int SLOT_WIDTH       = 32,
  parameter int BCLK_HALF_PERIOD = 4
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic [DATA_WIDTH-1:0] i_data_left,
  input  logic [DATA_WIDTH-1:0] i_data_right,
  input  logic                  i_data_valid,
  output logic                  o_bclk,
  output logic                  o_lrclk,
  output logic                  o_sdata,
  output logic                  o_frame_start,
  output logic                  o_underflow,
  output logic                  o_overrun
);

  localparam int CW = (BCLK_HALF_PERIOD > 1) ?
                      $clog2(BCLK_HALF_PERIOD) : 1;
  localparam int IW = $clog2(2 * SLOT_WIDTH);

  localparam logic [CW-1:0] CNT_LAST = CW'(BCLK_HALF_PERIOD - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(2 * SLOT_WIDTH - 1);
  localparam logic [IW-1:0] SLOT     = IW'(SLOT_WIDTH);
  localparam logic [IW-1:0] DW       = IW'(DATA_WIDTH);

  logic [CW-1:0]         div_cnt;
  logic [IW-1:0]         bit_idx;
  logic [IW-1:0]         idx_nxt;
  logic [IW-1:0]         slot_bit;
  logic                  lr_nxt;
  logic                  sd_nxt;
  logic                  tick;
  logic                  fall;
  logic                  load;
  logic                  hold_full;
  logic [DATA_WIDTH-1:0] hold_l;
  logic [DATA_WIDTH-1:0] hold_r;
  logic [DATA_WIDTH-1:0] act_l;
  logic [DATA_WIDTH-1:0] act_r;
  logic [DATA_WIDTH-1:0] word;
  logic [DATA_WIDTH-1:0] shifted;

  assign tick = (div_cnt == CNT_LAST);
  assign fall = tick & o_bclk;
  assign load = fall & (bit_idx == IDX_LAST);

  // Half-period divider toggling the bit clock at terminal count
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      div_cnt <= '0;
      o_bclk  <= 1'b0;
    end else if (tick) begin
      div_cnt <= '0;
      o_bclk  <= ~o_bclk;
    end else begin
      div_cnt <= div_cnt + CW'(1);
    end
  end

  // Next bit position and the serial bit it carries
  always_comb begin
    idx_nxt  = (bit_idx == IDX_LAST) ? '0 : bit_idx + IW'(1);
    lr_nxt   = (idx_nxt >= SLOT);
    slot_bit = lr_nxt ? idx_nxt - SLOT : idx_nxt;
    word     = lr_nxt ? act_r : act_l;
    shifted  = word << (slot_bit - IW'(1));
    sd_nxt   = (slot_bit != '0) && (slot_bit <= DW) &&
               shifted[DATA_WIDTH-1];
  end

  // Advance word select and data on each falling bit-clock edge
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      bit_idx <= IDX_LAST;
      o_lrclk <= 1'b0;
      o_sdata <= 1'b0;
    end else if (fall) begin
      bit_idx <= idx_nxt;
      o_lrclk <= lr_nxt;
      o_sdata <= sd_nxt;
    end
  end

  // Holding buffer, frame load into active registers, status pulses
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      hold_full     <= 1'b0;
      hold_l        <= '0;
      hold_r        <= '0;
      act_l         <= '0;
      act_r         <= '0;
      o_frame_start <= 1'b0;
      o_underflow   <= 1'b0;
      o_overrun     <= 1'b0;
    end else begin
      o_frame_start <= load;
      o_underflow   <= load & ~hold_full;
      o_overrun     <= i_data_valid & hold_full & ~load;
      if (load) begin
        if (hold_full) begin
          act_l <= hold_l;
          act_r <= hold_r;
        end else begin
`ifdef I2S_TX_UNDERFLOW_MUTE_EN
          act_l <= '0;
          act_r <= '0;
`else
          act_l <= act_l;
          act_r <= act_r;
`endif
        end
      end
      if (i_data_valid) begin
        hold_l    <= i_data_left;
        hold_r    <= i_data_right;
        hold_full <= 1'b1;
      end else if (load) begin
        hold_full <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_i2s_transmitter.sv
// Bench for i2s_transmitter: frame-level model, per-cycle compare,
// rising-BCLK deserialiser and directed literal expectations.
module tb_i2s_transmitter;

  localparam int DW = 24;
  localparam int SW = 32;
  localparam int H  = 2;
  localparam int BP = 2 * H;
  localparam int FP = BP * 2 * SW;

  logic          clk = 1'b0;
  logic          i_reset;
  logic [DW-1:0] i_data_left;
  logic [DW-1:0] i_data_right;
  logic          i_data_valid;
  logic          o_bclk;
  logic          o_lrclk;
  logic          o_sdata;
  logic          o_frame_start;
  logic          o_underflow;
  logic          o_overrun;

  always #5 clk = ~clk;

  i2s_transmitter #(
    .DATA_WIDTH(DW),
    .SLOT_WIDTH(SW),
    .BCLK_HALF_PERIOD(H)
  ) dut (
    .i_clock(clk),
    .i_reset(i_reset),
    .i_data_left(i_data_left),
    .i_data_right(i_data_right),
    .i_data_valid(i_data_valid),
    .o_bclk(o_bclk),
    .o_lrclk(o_lrclk),
    .o_sdata(o_sdata),
    .o_frame_start(o_frame_start),
    .o_underflow(o_underflow),
    .o_overrun(o_overrun)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Frame-level model: t counts clock edges since reset released
  int            t = 0;
  bit            started = 0;
  logic          m_full;
  logic [DW-1:0] m_hl, m_hr, m_al, m_ar;
  logic          e_fs, e_uf, e_ov;

  always @(posedge clk) begin
    bit ld;
    if (i_reset) begin
      t = 0; started = 1;
      m_full = 0; m_hl = 0; m_hr = 0; m_al = 0; m_ar = 0;
      e_fs = 0; e_uf = 0; e_ov = 0;
    end else if (started) begin
      t++;
      ld = (t >= BP) && ((t - BP) % FP == 0);
      e_fs = ld;
      e_uf = ld && !m_full;
      e_ov = i_data_valid && m_full && !ld;
      if (ld) begin
        if (m_full) begin
          m_al = m_hl; m_ar = m_hr;
        end else begin
`ifdef I2S_TX_UNDERFLOW_MUTE_EN
          m_al = 0; m_ar = 0;
`endif
        end
      end
      if (i_data_valid) begin
        m_hl = i_data_left; m_hr = i_data_right; m_full = 1;
      end else if (ld) begin
        m_full = 0;
      end
    end
  end

  function automatic logic exp_sd(int tt, logic [DW-1:0] l,
                                  logic [DW-1:0] r);
    int idx;
    int s;
    logic [DW-1:0] w;
    if (tt < BP) return 1'b0;
    idx = (tt / BP - 1) % (2 * SW);
    s = idx % SW;
    w = (idx >= SW) ? r : l;
    if (s >= 1 && s <= DW) return w[DW-s];
    return 1'b0;
  endfunction

  // Per-cycle compare against the model
  always @(negedge clk) begin
    logic eb, el, es;
    if (started) begin
      eb = ((t / H) % 2) == 1;
      el = (t >= BP) && (((t / BP - 1) % (2 * SW)) >= SW);
      es = exp_sd(t, m_al, m_ar);
      chk("bclk", 32'(o_bclk), 32'(eb));
      chk("lrclk", 32'(o_lrclk), 32'(el));
      chk("sdata", 32'(o_sdata), 32'(es));
      chk("frame_start", 32'(o_frame_start), 32'(e_fs));
      chk("underflow", 32'(o_underflow), 32'(e_uf));
      chk("overrun", 32'(o_overrun), 32'(e_ov));
    end
  end

  // Receiver-side deserialiser sampling on rising BCLK
  logic [DW-1:0] dq[$];
  logic [DW-1:0] dword;
  int            dcnt;
  logic          prev_lr;
  bit            armed = 0;

  always @(negedge clk) begin
    if (i_reset) begin
      armed = 0; prev_lr = 1;
    end else if (o_frame_start) begin
      armed = 1;
    end
  end

  always @(posedge o_bclk) begin
    if (armed) begin
      if (o_lrclk !== prev_lr) begin
        prev_lr = o_lrclk; dcnt = 0; dword = 0;
      end else begin
        dcnt++;
      end
      if (dcnt == 0 || dcnt > DW) begin
        chk("slot_pad", 32'(o_sdata), 32'd0);
      end else begin
        dword = {dword[DW-2:0], o_sdata};
        if (dcnt == DW) dq.push_back(dword);
      end
    end
  end

  task automatic wait_t(int target);
    int guard = 0;
    while (t < target && guard < 5000) begin
      @(negedge clk);
      guard++;
    end
    chk("wait_t", 32'(t), 32'(target));
  endtask

  task automatic send(logic [DW-1:0] l, logic [DW-1:0] r);
    i_data_left  = l;
    i_data_right = r;
    i_data_valid = 1'b1;
    @(negedge clk);
    i_data_valid = 1'b0;
  endtask

  task automatic chk_all_zero(string tag);
    chk({tag, "_bclk"}, 32'(o_bclk), 32'd0);
    chk({tag, "_lrclk"}, 32'(o_lrclk), 32'd0);
    chk({tag, "_sdata"}, 32'(o_sdata), 32'd0);
    chk({tag, "_fs"}, 32'(o_frame_start), 32'd0);
    chk({tag, "_uf"}, 32'(o_underflow), 32'd0);
    chk({tag, "_ov"}, 32'(o_overrun), 32'd0);
  endtask

  task automatic post_reset_checks();
    wait_t(1);
    chk("t1_bclk", 32'(o_bclk), 32'd0);
    chk("t1_fs", 32'(o_frame_start), 32'd0);
    wait_t(2);
    chk("t2_bclk", 32'(o_bclk), 32'd1);
    wait_t(3);
    chk("t3_bclk", 32'(o_bclk), 32'd1);
    chk("t3_fs", 32'(o_frame_start), 32'd0);
    wait_t(4);
    chk("t4_bclk", 32'(o_bclk), 32'd0);
    chk("t4_fs", 32'(o_frame_start), 32'd1);
    chk("t4_uf", 32'(o_underflow), 32'd1);
    chk("t4_lrclk", 32'(o_lrclk), 32'd0);
  endtask

  logic [DW-1:0] exp_words[15];

  initial begin
    exp_words = '{
      24'h000000, 24'h000000,
      24'hABCDEF, 24'h123456,
`ifdef I2S_TX_UNDERFLOW_MUTE_EN
      24'h000000, 24'h000000,
`else
      24'hABCDEF, 24'h123456,
`endif
      24'h7FFFFF, 24'h654321,
      24'h111111, 24'h222222,
      24'h800000,
      24'h000000, 24'h000000,
      24'h000000, 24'h000000
    };
    i_reset      = 1'b1;
    i_data_valid = 1'b0;
    i_data_left  = '0;
    i_data_right = '0;
    repeat (5) @(negedge clk);
    chk_all_zero("reset");
    i_reset = 1'b0;
    post_reset_checks();

    wait_t(99);
    send(24'hABCDEF, 24'h123456);
    wait_t(260);
    chk("f1_fs", 32'(o_frame_start), 32'd1);
    chk("f1_uf", 32'(o_underflow), 32'd0);

    wait_t(516);
    chk("f2_fs", 32'(o_frame_start), 32'd1);
    chk("f2_uf", 32'(o_underflow), 32'd1);

    wait_t(599);
    send(24'h000001, 24'h000002);
    chk("ov_first", 32'(o_overrun), 32'd0);
    wait_t(609);
    send(24'h7FFFFF, 24'h654321);
    chk("ov_second", 32'(o_overrun), 32'd1);
    wait_t(611);
    chk("ov_after", 32'(o_overrun), 32'd0);
    wait_t(772);
    chk("f3_uf", 32'(o_underflow), 32'd0);

    wait_t(899);
    send(24'h111111, 24'h222222);
    wait_t(1027);
    send(24'h800000, 24'h0F0F0F);
    chk("f4_fs", 32'(o_frame_start), 32'd1);
    chk("f4_uf", 32'(o_underflow), 32'd0);
    chk("f4_ov", 32'(o_overrun), 32'd0);
    wait_t(1284);
    chk("f5_fs", 32'(o_frame_start), 32'd1);
    chk("f5_uf", 32'(o_underflow), 32'd0);

    wait_t(1399);
    send(24'h555555, 24'hAAAAAA);
    wait_t(1449);
    i_reset = 1'b1;
    @(negedge clk);
    chk_all_zero("midreset");
    repeat (2) @(negedge clk);
    i_reset = 1'b0;
    post_reset_checks();
    wait_t(540);

    chk("dec_count", 32'(dq.size()), 32'd15);
    for (int i = 0; i < 15; i++) begin
      if (i < dq.size())
        chk($sformatf("dec%0d", i), 32'(dq[i]), 32'(exp_words[i]));
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
